conv_core_ctrl: RTL and testbench

Sequencer for the 3x3 convolution PE array (16 input pixels x 3 filter taps -> 14 partial sums per output row). It streams input rows from the row buffer and filter rows from the filter registers into the array over three beats per output row. It waits for the array pipeline to settle, then presents each 14-sum output row to the downstream writer through a valid/ready handshake. It sits between the layer-level control FSM (start/done) and the array plus its row and filter memories.

---
 rtl/conv_core_ctrl.sv | 129 ++++++++++++
 tb/tb_conv_core_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_core_ctrl.sv
// Row sequencer for the 3x3 convolution PE array: fetches three input rows per
// output row, waits for the array pipeline, then hands the 14 sums downstream.
module conv_core_ctrl #(
  parameter int ROW_AW   = 8,
  parameter int CORE_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ROW_AW-1:0] cfg_rows,
  output logic              busy,
  output logic              done,
  output logic              row_rd_en,
  output logic [ROW_AW-1:0] row_rd_addr,
  output logic [1:0]        filt_sel,
  output logic              core_en,
  output logic              core_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_AW-1:0] out_row
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  localparam int DW = $clog2(CORE_LAT + 1) + 1;

  state_t            state_reg, state_next;
  logic [ROW_AW-1:0] row_reg;
  logic [ROW_AW-1:0] rows_reg;
  logic [1:0]        k_reg;
  logic [DW-1:0]     drain_reg;
  logic              en_d_reg;
  logic              clr_d_reg;
  logic [1:0]        filt_d_reg;

  logic cfg_ok;
  logic last_row;
  logic drain_done;

  assign cfg_ok     = (cfg_rows >= ROW_AW'(3));
  // Only meaningful while rows_reg >= 3, which holds whenever we are in OUT.
  assign last_row   = (row_reg == rows_reg - ROW_AW'(3));
  assign drain_done = (drain_reg == DW'(CORE_LAT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = cfg_ok ? S_FETCH : S_DONE;
      S_FETCH: if (k_reg == 2'd2) state_next = S_DRAIN;
      S_DRAIN: if (drain_done) state_next = S_OUT;
      S_OUT:   if (out_ready) state_next = last_row ? S_DONE : S_FETCH;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    row_rd_en   = 1'b0;
    row_rd_addr = '0;
    out_valid   = 1'b0;
    out_row     = '0;
    core_en     = en_d_reg;
    core_clr    = clr_d_reg;
    filt_sel    = filt_d_reg;
    case (state_reg)
      S_FETCH: begin
        busy        = 1'b1;
        row_rd_en   = 1'b1;
        row_rd_addr = row_reg + ROW_AW'(k_reg);
      end
      S_DRAIN: busy = 1'b1;
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_row   = row_reg;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_reg   <= '0;
      rows_reg  <= '0;
      k_reg     <= '0;
      drain_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          rows_reg <= cfg_rows;
          row_reg  <= '0;
          k_reg    <= '0;
        end
        S_FETCH: k_reg <= (k_reg == 2'd2) ? 2'd0 : k_reg + 2'd1;
        S_DRAIN: drain_reg <= drain_done ? '0 : drain_reg + DW'(1);
        S_OUT:   if (out_ready && !last_row) row_reg <= row_reg + ROW_AW'(1);
        default: ;
      endcase
    end
  end

  // Read data lands one cycle after the strobe, so beats trail the fetch by one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_d_reg   <= 1'b0;
      clr_d_reg  <= 1'b0;
      filt_d_reg <= '0;
    end else begin
      en_d_reg   <= row_rd_en;
      clr_d_reg  <= row_rd_en && (k_reg == 2'd0);
      filt_d_reg <= row_rd_en ? k_reg : 2'd0;
    end
  end

endmodule

// File: tb/tb_conv_core_ctrl.sv
// Directed bench for conv_core_ctrl: default-latency instance plus a CORE_LAT=0
// instance for the maximum-height tile.
module tb_conv_core_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       sel;
  logic [7:0] cfg_rows;
  logic       out_ready;

  logic       start_a, start_b;
  logic       busy_a, done_a, rd_en_a, en_a, clr_a, valid_a;
  logic [7:0] addr_a, row_a;
  logic [1:0] fsel_a;
  logic       busy_b, done_b, rd_en_b, en_b, clr_b, valid_b;
  logic [7:0] addr_b, row_b;
  logic [1:0] fsel_b;

  int checks = 0;
  int failures = 0;

  logic       s_rd_en [0:1399];
  logic [7:0] s_addr  [0:1399];
  logic [1:0] s_fsel  [0:1399];
  logic       s_en    [0:1399];
  logic       s_clr   [0:1399];
  logic       s_valid [0:1399];
  logic [7:0] s_row   [0:1399];
  logic       s_done  [0:1399];
  logic       s_busy  [0:1399];

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  always #5 clk = ~clk;

  conv_core_ctrl #(.ROW_AW(8), .CORE_LAT(2)) dut (
    .clk(clk), .rstn(rstn), .start(start_a), .cfg_rows(cfg_rows),
    .busy(busy_a), .done(done_a), .row_rd_en(rd_en_a), .row_rd_addr(addr_a),
    .filt_sel(fsel_a), .core_en(en_a), .core_clr(clr_a), .out_valid(valid_a),
    .out_ready(out_ready), .out_row(row_a)
  );

  conv_core_ctrl #(.ROW_AW(8), .CORE_LAT(0)) dut0 (
    .clk(clk), .rstn(rstn), .start(start_b), .cfg_rows(cfg_rows),
    .busy(busy_b), .done(done_b), .row_rd_en(rd_en_b), .row_rd_addr(addr_b),
    .filt_sel(fsel_b), .core_en(en_b), .core_clr(clr_b), .out_valid(valid_b),
    .out_ready(out_ready), .out_row(row_b)
  );

  function automatic int find(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return i;
    return -1;
  endfunction

  // Cycle 0 carries the start; extra starts use cfg_rows=7 so a wrongly
  // accepted one changes the trace. rst_at pulls rstn low for that cycle.
  task automatic run(input bit use_b, input logic [7:0] cfg, input int n,
                     input int rdy_lo_a, input int rdy_lo_b,
                     input int s2a, input int s2b, input int rst_at);
    sel = use_b;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      start     = (c == 0) || (c == s2a) || (c == s2b);
      cfg_rows  = (c == 0) ? cfg : 8'd7;
      out_ready = !(c >= rdy_lo_a && c <= rdy_lo_b);
      rstn      = (c != rst_at);
      #1;
      s_rd_en[c] = use_b ? rd_en_b : rd_en_a;
      s_addr[c]  = use_b ? addr_b  : addr_a;
      s_fsel[c]  = use_b ? fsel_b  : fsel_a;
      s_en[c]    = use_b ? en_b    : en_a;
      s_clr[c]   = use_b ? clr_b   : clr_a;
      s_valid[c] = use_b ? valid_b : valid_a;
      s_row[c]   = use_b ? row_b   : row_a;
      s_done[c]  = use_b ? done_b  : done_a;
      s_busy[c]  = use_b ? busy_b  : busy_a;
      $display("cycle %0d rd_en=%b addr=%0d en=%b clr=%b fsel=%0d valid=%b row=%0d done=%b busy=%b",
               c, s_rd_en[c], s_addr[c], s_en[c], s_clr[c], s_fsel[c],
               s_valid[c], s_row[c], s_done[c], s_busy[c]);
    end
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1; rstn = 1'b1;
  endtask

  // Beats follow fetch cycles by one; filt_sel/core_clr follow the tap order.
  task automatic check_trace(input string tag, input int n,
                             input int fc[$], input int fa[$],
                             input int vc[$], input int vr[$],
                             input int done_c, input int busy_lo, input int busy_hi);
    int fi, ei, vi;
    for (int c = 0; c < n; c++) begin
      fi = find(fc, c);
      ei = find(fc, c - 1);
      vi = find(vc, c);
      checks++;
      if (s_rd_en[c] !== (fi >= 0)) begin
        failures++;
        $display("FAIL %s rd_en cycle %0d got %b want %b", tag, c, s_rd_en[c], fi >= 0);
      end
      if (fi >= 0) begin
        checks++;
        if (s_addr[c] !== 8'(fa[fi])) begin
          failures++;
          $display("FAIL %s addr cycle %0d got %0d want %0d", tag, c, s_addr[c], fa[fi]);
        end
      end
      checks++;
      if (s_en[c] !== (ei >= 0)) begin
        failures++;
        $display("FAIL %s core_en cycle %0d got %b want %b", tag, c, s_en[c], ei >= 0);
      end
      if (ei >= 0) begin
        checks++;
        if (s_fsel[c] !== 2'(ei % 3)) begin
          failures++;
          $display("FAIL %s filt_sel cycle %0d got %0d want %0d", tag, c, s_fsel[c], ei % 3);
        end
      end
      checks++;
      if (s_clr[c] !== (ei >= 0 && ei % 3 == 0)) begin
        failures++;
        $display("FAIL %s core_clr cycle %0d got %b want %b", tag, c, s_clr[c], ei >= 0 && ei % 3 == 0);
      end
      checks++;
      if (s_valid[c] !== (vi >= 0)) begin
        failures++;
        $display("FAIL %s out_valid cycle %0d got %b want %b", tag, c, s_valid[c], vi >= 0);
      end
      if (vi >= 0) begin
        checks++;
        if (s_row[c] !== 8'(vr[vi])) begin
          failures++;
          $display("FAIL %s out_row cycle %0d got %0d want %0d", tag, c, s_row[c], vr[vi]);
        end
      end
      checks++;
      if (s_done[c] !== (c == done_c)) begin
        failures++;
        $display("FAIL %s done cycle %0d got %b want %b", tag, c, s_done[c], c == done_c);
      end
      checks++;
      if (s_busy[c] !== (c >= busy_lo && c <= busy_hi)) begin
        failures++;
        $display("FAIL %s busy cycle %0d got %b want %b", tag, c, s_busy[c], c >= busy_lo && c <= busy_hi);
      end
    end
  endtask

  task automatic test_reset();
    logic [24:0] va, vb;
    rstn = 1'b0; start = 1'b0; sel = 1'b0; cfg_rows = 8'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    va = {busy_a, done_a, rd_en_a, addr_a, fsel_a, en_a, clr_a, valid_a, row_a};
    vb = {busy_b, done_b, rd_en_b, addr_b, fsel_b, en_b, clr_b, valid_b, row_b};
    checks++;
    if (va !== '0) begin failures++; $display("FAIL reset_outputs_a got %h want 0", va); end
    checks++;
    if (vb !== '0) begin failures++; $display("FAIL reset_outputs_b got %h want 0", vb); end
    $display("reset outputs a=%h b=%h", va, vb);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    run(1'b0, 8'd5, 26, -1, -1, -1, -1, -1);
    check_trace("nominal", 26, '{1,2,3,8,9,10,15,16,17}, '{0,1,2,1,2,3,2,3,4},
                '{7,14,21}, '{0,1,2}, 22, 1, 21);
  endtask

  task automatic test_backpressure();
    run(1'b0, 8'd3, 16, 7, 11, -1, -1, -1);
    check_trace("backpressure", 16, '{1,2,3}, '{0,1,2},
                '{7,8,9,10,11,12}, '{0,0,0,0,0,0}, 13, 1, 12);
  endtask

  task automatic test_short_tile();
    int none[$];
    run(1'b0, 8'd2, 6, -1, -1, -1, -1, -1);
    check_trace("short", 6, none, none, none, none, 1, 1, 0);
  endtask

  task automatic test_ignored_start();
    run(1'b0, 8'd5, 30, -1, -1, 5, 22, -1);
    check_trace("ignored_start", 30, '{1,2,3,8,9,10,15,16,17}, '{0,1,2,1,2,3,2,3,4},
                '{7,14,21}, '{0,1,2}, 22, 1, 21);
  endtask

  task automatic test_mid_reset();
    logic [24:0] v;
    run(1'b0, 8'd5, 12, -1, -1, -1, -1, 9);
    checks++;
    if (s_rd_en[8] !== 1'b1 || s_addr[8] !== 8'd1) begin
      failures++;
      $display("FAIL mid_reset pre_fetch got en=%b addr=%0d want en=1 addr=1", s_rd_en[8], s_addr[8]);
    end
    v = {s_busy[9], s_done[9], s_rd_en[9], s_addr[9], s_fsel[9], s_en[9], s_clr[9], s_valid[9], s_row[9]};
    checks++;
    if (v !== '0) begin failures++; $display("FAIL mid_reset outputs got %h want 0", v); end
    for (int c = 10; c < 12; c++) begin
      checks++;
      if ({s_busy[c], s_rd_en[c], s_en[c], s_valid[c]} !== 4'b0) begin
        failures++;
        $display("FAIL mid_reset idle cycle %0d got %b want 0000", c,
                 {s_busy[c], s_rd_en[c], s_en[c], s_valid[c]});
      end
    end
    run(1'b0, 8'd4, 18, -1, -1, -1, -1, -1);
    check_trace("after_reset", 18, '{1,2,3,8,9,10}, '{0,1,2,1,2,3},
                '{7,14}, '{0,1}, 15, 1, 14);
  endtask

  task automatic test_max_rows();
    int n_rd, n_valid, addr_err, valid_err, last_addr, done_c, r, k;
    n_rd = 0; n_valid = 0; addr_err = 0; valid_err = 0; last_addr = -1; done_c = -1;
    run(1'b1, 8'd255, 1270, -1, -1, -1, -1, -1);
    for (int c = 0; c < 1270; c++) begin
      if (s_rd_en[c] === 1'b1) begin
        n_rd++;
        r = (c - 1) / 5;
        k = (c - 1) % 5;
        if (k > 2 || s_addr[c] !== 8'(r + k)) addr_err++;
        last_addr = int'(s_addr[c]);
      end
      if (s_valid[c] === 1'b1) n_valid++;
      if (s_valid[c] !== (c >= 5 && c <= 1265 && c % 5 == 0)) valid_err++;
      else if (s_valid[c] === 1'b1 && s_row[c] !== 8'(c / 5 - 1)) valid_err++;
      if (s_done[c] === 1'b1 && done_c < 0) done_c = c;
    end
    checks++;
    if (n_valid != 253) begin failures++; $display("FAIL max_rows valid_count got %0d want 253", n_valid); end
    checks++;
    if (n_rd != 759) begin failures++; $display("FAIL max_rows fetch_count got %0d want 759", n_rd); end
    checks++;
    if (last_addr != 254) begin failures++; $display("FAIL max_rows last_addr got %0d want 254", last_addr); end
    checks++;
    if (addr_err != 0) begin failures++; $display("FAIL max_rows addr_errors got %0d want 0", addr_err); end
    checks++;
    if (valid_err != 0) begin failures++; $display("FAIL max_rows valid_errors got %0d want 0", valid_err); end
    checks++;
    if (done_c != 1266) begin failures++; $display("FAIL max_rows done_cycle got %0d want 1266", done_c); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_short_tile();
    test_ignored_start();
    test_mid_reset();
    test_max_rows();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
